// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - fetch stage: PC -> instruction-memory request/ack -> held instruction for decode
module instruction_fetch #(
    parameter int ADDR_WIDTH  = 16,
    parameter int INSTR_WIDTH = 16
) (
    input  logic                   clk_pi,
    input  logic                   reset_pi,
    input  logic                   clk_en_pi,
    input  logic                   halt_pi,
    input  logic                   flush_pi,
    input  logic [ADDR_WIDTH-1:0]  pc_pi,
    output logic                   pc_advance_po,
    output logic                   imem_req_po,
    output logic [ADDR_WIDTH-1:0]  imem_addr_po,
    input  logic                   imem_ack_pi,
    input  logic [INSTR_WIDTH-1:0] imem_rdata_pi,
    output logic [INSTR_WIDTH-1:0] instr_po,
    output logic [ADDR_WIDTH-1:0]  instr_pc_po,
    output logic                   instr_valid_po,
    input  logic                   instr_ready_pi,
    output logic [15:0]            fetch_count_po,
    output logic                   align_err_po
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_HOLD  = 2'd3;

    logic [1:0]            state;
    logic                  pc_adv_q;
    logic                  start_fetch;
    logic [ADDR_WIDTH-1:0] aligned_pc;

    assign aligned_pc = {pc_pi[ADDR_WIDTH-1:1], 1'b0};

    // A new request is issued from IDLE, or straight out of HOLD once decode takes the instruction.
    assign start_fetch = !flush_pi && !halt_pi &&
                         ((state == S_IDLE) || ((state == S_HOLD) && instr_ready_pi));

    // The pulse register holds across a disabled cycle so the PC still steps exactly once.
    assign pc_advance_po = pc_adv_q & clk_en_pi;

    always_ff @(posedge clk_pi or posedge reset_pi) begin
        if (reset_pi) begin
            state          <= S_IDLE;
            imem_req_po    <= 1'b0;
            imem_addr_po   <= '0;
            instr_po       <= '0;
            instr_pc_po    <= '0;
            instr_valid_po <= 1'b0;
            pc_adv_q       <= 1'b0;
            fetch_count_po <= '0;
            align_err_po   <= 1'b0;
        end else if (clk_en_pi) begin
            pc_adv_q <= 1'b0;
            case (state)
                S_IDLE: begin
                end
                S_WAIT: begin
                    if (imem_ack_pi) begin
                        imem_req_po <= 1'b0;
                        if (flush_pi) begin
                            state <= S_IDLE;
                        end else begin
                            // imem_addr_po is held stable for the whole request, so it is the fetch PC
                            instr_po       <= imem_rdata_pi;
                            instr_pc_po    <= imem_addr_po;
                            instr_valid_po <= 1'b1;
                            pc_adv_q       <= 1'b1;
                            fetch_count_po <= fetch_count_po + 16'd1;
                            state          <= S_HOLD;
                        end
                    end else if (flush_pi) begin
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (imem_ack_pi) begin
                        imem_req_po <= 1'b0;
                        state       <= S_IDLE;
                    end
                end
                S_HOLD: begin
                    if (flush_pi || instr_ready_pi) begin
                        instr_valid_po <= 1'b0;
                        state          <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase

            if (start_fetch) begin
                imem_req_po  <= 1'b1;
                imem_addr_po <= aligned_pc;
                state        <= S_WAIT;
                if (pc_pi[0]) begin
                    align_err_po <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - directed vector table plus randomized run against a transaction-level model
module tb_instruction_fetch;

    logic        clk_pi = 1'b0;
    logic        reset_pi = 1'b1;
    logic        clk_en_pi = 1'b1;
    logic        halt_pi = 1'b0;
    logic        flush_pi = 1'b0;
    logic [15:0] pc_pi = '0;
    logic        pc_advance_po;
    logic        imem_req_po;
    logic [15:0] imem_addr_po;
    logic        imem_ack_pi = 1'b0;
    logic [15:0] imem_rdata_pi = '0;
    logic [15:0] instr_po;
    logic [15:0] instr_pc_po;
    logic        instr_valid_po;
    logic        instr_ready_pi = 1'b0;
    logic [15:0] fetch_count_po;
    logic        align_err_po;

    int checks = 0;
    int failures = 0;

    instruction_fetch #(.ADDR_WIDTH(16), .INSTR_WIDTH(16)) dut (
        .clk_pi         (clk_pi),
        .reset_pi       (reset_pi),
        .clk_en_pi      (clk_en_pi),
        .halt_pi        (halt_pi),
        .flush_pi       (flush_pi),
        .pc_pi          (pc_pi),
        .pc_advance_po  (pc_advance_po),
        .imem_req_po    (imem_req_po),
        .imem_addr_po   (imem_addr_po),
        .imem_ack_pi    (imem_ack_pi),
        .imem_rdata_pi  (imem_rdata_pi),
        .instr_po       (instr_po),
        .instr_pc_po    (instr_pc_po),
        .instr_valid_po (instr_valid_po),
        .instr_ready_pi (instr_ready_pi),
        .fetch_count_po (fetch_count_po),
        .align_err_po   (align_err_po)
    );

    always #5 clk_pi = ~clk_pi;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic en, halt, flush, ack, ready;
        logic [15:0] pc, rdata;
        logic e_req;
        logic [15:0] e_addr;
        logic e_valid;
        logic [15:0] e_instr, e_ipc;
        logic e_adv;
        logic [15:0] e_cnt;
        logic e_err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic en, halt, flush, ack, ready,
                                input logic [15:0] pc, rdata,
                                input logic req, input logic [15:0] addr,
                                input logic valid, input logic [15:0] instr, ipc,
                                input logic adv, input logic [15:0] cnt, input logic err);
        vec_t v;
        v.en = en; v.halt = halt; v.flush = flush; v.ack = ack; v.ready = ready;
        v.pc = pc; v.rdata = rdata; v.e_req = req; v.e_addr = addr; v.e_valid = valid;
        v.e_instr = instr; v.e_ipc = ipc; v.e_adv = adv; v.e_cnt = cnt; v.e_err = err;
        return v;
    endfunction

    // Reference model: one outstanding memory request, a discard flag, and a one-deep holding buffer.
    bit          m_req, m_discard, m_valid, m_adv, m_err;
    logic [15:0] m_addr, m_instr, m_ipc;
    int unsigned m_cnt;

    task automatic model_reset();
        m_req = 0; m_discard = 0; m_valid = 0; m_adv = 0; m_err = 0;
        m_addr = 0; m_instr = 0; m_ipc = 0; m_cnt = 0;
    endtask

    task automatic model_issue();
        m_req = 1;
        m_addr = pc_pi & 16'hFFFE;
        if (pc_pi[0]) m_err = 1;
    endtask

    task automatic model_edge();
        if (!clk_en_pi) return;
        m_adv = 0;
        if (m_req) begin
            if (imem_ack_pi) begin
                m_req = 0;
                if (!m_discard && !flush_pi) begin
                    m_instr = imem_rdata_pi;
                    m_ipc = m_addr;
                    m_valid = 1;
                    m_adv = 1;
                    m_cnt = (m_cnt + 1) % 65536;
                end
                m_discard = 0;
            end else if (flush_pi) begin
                m_discard = 1;
            end
        end else if (m_valid) begin
            if (flush_pi) m_valid = 0;
            else if (instr_ready_pi) begin
                m_valid = 0;
                if (!halt_pi) model_issue();
            end
        end else if (!halt_pi && !flush_pi) begin
            model_issue();
        end
    endtask

    task automatic check_model();
        check("rnd_req", imem_req_po, m_req);
        if (m_req) check("rnd_addr", imem_addr_po, m_addr);
        check("rnd_valid", instr_valid_po, m_valid);
        if (m_valid) begin
            check("rnd_instr", instr_po, m_instr);
            check("rnd_ipc", instr_pc_po, m_ipc);
        end
        check("rnd_adv", pc_advance_po, m_adv && clk_en_pi);
        check("rnd_cnt", fetch_count_po, m_cnt[15:0]);
        check("rnd_err", align_err_po, m_err);
    endtask

    initial begin
        // en,halt,flush,ack,ready, pc, rdata | req, addr, valid, instr, ipc, adv, cnt, err
        vecs.push_back(mk(1,1,0,0,0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0, 0));
        vecs.push_back(mk(1,0,0,0,0, 16'h0000, 16'h0000, 1, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0, 0));
        vecs.push_back(mk(1,0,0,1,0, 16'h0000, 16'h1234, 0, 16'h0000, 1, 16'h1234, 16'h0000, 1, 1, 0));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(1,0,0,0,0, 16'h0002, 16'h0000, 0, 16'h0000, 1, 16'h1234, 16'h0000, 0, 1, 0));
        vecs.push_back(mk(1,0,0,0,1, 16'h0002, 16'h0000, 1, 16'h0002, 0, 16'h0000, 16'h0000, 0, 1, 0));
        vecs.push_back(mk(0,0,0,1,0, 16'h0002, 16'hBEEF, 1, 16'h0002, 0, 16'h0000, 16'h0000, 0, 1, 0));
        vecs.push_back(mk(1,0,0,1,0, 16'h0002, 16'hBEEF, 0, 16'h0000, 1, 16'hBEEF, 16'h0002, 1, 2, 0));
        vecs.push_back(mk(0,0,0,0,1, 16'h0004, 16'h0000, 0, 16'h0000, 1, 16'hBEEF, 16'h0002, 0, 2, 0));
        vecs.push_back(mk(1,0,1,0,1, 16'h0004, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 2, 0));
        vecs.push_back(mk(1,0,0,0,0, 16'h0010, 16'h0000, 1, 16'h0010, 0, 16'h0000, 16'h0000, 0, 2, 0));
        vecs.push_back(mk(1,0,1,0,0, 16'h0010, 16'h0000, 1, 16'h0010, 0, 16'h0000, 16'h0000, 0, 2, 0));
        vecs.push_back(mk(1,0,0,0,0, 16'h0040, 16'h0000, 1, 16'h0010, 0, 16'h0000, 16'h0000, 0, 2, 0));
        vecs.push_back(mk(1,0,1,0,0, 16'h0040, 16'h0000, 1, 16'h0010, 0, 16'h0000, 16'h0000, 0, 2, 0));
        vecs.push_back(mk(1,0,0,1,0, 16'h0040, 16'hDEAD, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 2, 0));
        vecs.push_back(mk(1,0,0,0,0, 16'h0040, 16'h0000, 1, 16'h0040, 0, 16'h0000, 16'h0000, 0, 2, 0));
        vecs.push_back(mk(1,0,1,1,0, 16'h0040, 16'h1111, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 2, 0));
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(1,1,0,0,0, 16'h0040, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 2, 0));
        vecs.push_back(mk(1,0,0,0,0, 16'h0005, 16'h0000, 1, 16'h0004, 0, 16'h0000, 16'h0000, 0, 2, 1));
        vecs.push_back(mk(1,0,0,1,0, 16'h0005, 16'h5555, 0, 16'h0000, 1, 16'h5555, 16'h0004, 1, 3, 1));
        vecs.push_back(mk(1,1,0,0,1, 16'h0006, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 3, 1));
        vecs.push_back(mk(1,0,0,0,0, 16'h0006, 16'h0000, 1, 16'h0006, 0, 16'h0000, 16'h0000, 0, 3, 1));
        vecs.push_back(mk(1,0,0,1,0, 16'h0006, 16'h7777, 0, 16'h0000, 1, 16'h7777, 16'h0006, 1, 4, 1));
        vecs.push_back(mk(1,0,0,0,1, 16'h0008, 16'h0000, 1, 16'h0008, 0, 16'h0000, 16'h0000, 0, 4, 1));

        repeat (2) @(negedge clk_pi);
        check("reset_req", imem_req_po, 0);
        check("reset_addr", imem_addr_po, 0);
        check("reset_valid", instr_valid_po, 0);
        check("reset_instr", instr_po, 0);
        check("reset_ipc", instr_pc_po, 0);
        check("reset_adv", pc_advance_po, 0);
        check("reset_cnt", fetch_count_po, 0);
        check("reset_err", align_err_po, 0);
        reset_pi = 1'b0;

        foreach (vecs[i]) begin
            clk_en_pi = vecs[i].en; halt_pi = vecs[i].halt; flush_pi = vecs[i].flush;
            imem_ack_pi = vecs[i].ack; instr_ready_pi = vecs[i].ready;
            pc_pi = vecs[i].pc; imem_rdata_pi = vecs[i].rdata;
            @(posedge clk_pi);
            @(negedge clk_pi);
            check($sformatf("v%0d_req", i), imem_req_po, vecs[i].e_req);
            if (vecs[i].e_req) check($sformatf("v%0d_addr", i), imem_addr_po, vecs[i].e_addr);
            check($sformatf("v%0d_valid", i), instr_valid_po, vecs[i].e_valid);
            if (vecs[i].e_valid) begin
                check($sformatf("v%0d_instr", i), instr_po, vecs[i].e_instr);
                check($sformatf("v%0d_ipc", i), instr_pc_po, vecs[i].e_ipc);
            end
            check($sformatf("v%0d_adv", i), pc_advance_po, vecs[i].e_adv);
            check($sformatf("v%0d_cnt", i), fetch_count_po, vecs[i].e_cnt);
            check($sformatf("v%0d_err", i), align_err_po, vecs[i].e_err);
        end

        // Last vector left a request outstanding; an asynchronous reset must drop it before any edge.
        clk_en_pi = 1'b1; halt_pi = 1'b0; flush_pi = 1'b0; imem_ack_pi = 1'b0; instr_ready_pi = 1'b0;
        #2 reset_pi = 1'b1;
        #1;
        check("areset_req", imem_req_po, 0);
        check("areset_addr", imem_addr_po, 0);
        check("areset_cnt", fetch_count_po, 0);
        check("areset_err", align_err_po, 0);
        check("areset_valid", instr_valid_po, 0);
        @(negedge clk_pi);
        reset_pi = 1'b0;
        model_reset();

        for (int c = 0; c < 4000; c++) begin
            check_model();
            clk_en_pi      = ($urandom_range(0, 9) != 0);
            halt_pi        = ($urandom_range(0, 9) == 0);
            flush_pi       = ($urandom_range(0, 9) == 0);
            imem_ack_pi    = ($urandom_range(0, 1) == 1);
            instr_ready_pi = ($urandom_range(0, 4) < 3);
            imem_rdata_pi  = 16'($urandom);
            pc_pi          = 16'($urandom) & (($urandom_range(0, 49) == 0) ? 16'hFFFF : 16'hFFFE);
            @(posedge clk_pi);
            model_edge();
            @(negedge clk_pi);
        end
        check_model();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
